fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 4, meaning the PC increment per accepted fetch, modulo 256.
REQ-002 The block SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-003 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  level request to begin or resume fetching.
REQ-006 The block SHALL have port halt  input  1  level request to stop fetching.
REQ-007 The block SHALL have port br_valid  input  1  branch redirect strobe, one cycle.
REQ-008 The block SHALL have port br_target  input  8  branch destination address.
REQ-009 The block SHALL have port mem_ready  input  1  memory accepts the current request this cycle.
REQ-010 The block SHALL have port mem_rdata  input  8  instruction byte, valid when mem_ready=1.
REQ-011 The block SHALL have port mem_req  output  1  fetch request, registered.
REQ-012 The block SHALL have port pc  output  8  current fetch address, registered.
REQ-013 The block SHALL have port instr  output  8  last fetched instruction, registered.
REQ-014 The block SHALL have port instr_valid  output  1  one-cycle pulse, instr updated.
REQ-015 The block SHALL have port state_o  output  2  encoded state: 00 IDLE, 01 FETCH, 10 HALTED.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, FETCH and HALTED; encoding 11 SHALL return to IDLE on the next edge.
REQ-017 In IDLE, start=1 with halt=0 SHALL move to FETCH on the next edge; pc SHALL be unchanged.
REQ-018 In IDLE or HALTED, halt=1 SHALL select HALTED on the next edge; halt SHALL win over simultaneous start.
REQ-019 In HALTED, start=1 with halt=0 SHALL move to FETCH; otherwise the FSM SHALL remain in HALTED.
REQ-020 mem_req SHALL equal 1 exactly while in FETCH, and pc SHALL remain stable while mem_req=1 and mem_ready=0.
REQ-021 An accept is defined as FETCH and mem_ready=1 in the same cycle.
REQ-022 On accept, instr SHALL load mem_rdata and instr_valid SHALL be 1 in the following cycle only.
REQ-023 On accept, next pc SHALL be br_target if br_valid=1 this cycle; else the pending target if one is held; else (pc+STEP) mod 256, wrapping 8'hFC+4 to 8'h00.
REQ-024 br_valid in FETCH without accept SHALL capture br_target into a pending register; a later br_valid SHALL overwrite it (latest wins).
REQ-025 The pending register SHALL clear on the accept that consumes it.
REQ-026 br_valid in IDLE or HALTED SHALL load pc with br_target on the next edge and SHALL clear any pending target.
REQ-027 halt=1 in FETCH SHALL NOT abandon an outstanding request; the FSM SHALL leave FETCH for HALTED only on an accept.
REQ-028 The pc update of REQ-023 SHALL still occur on the accept of REQ-027.
REQ-029 Without halt, FETCH SHALL continue back-to-back, with one request per cycle when mem_ready is held at 1.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force state IDLE, pc=RESET_PC, mem_req=0, instr=8'h00, instr_valid=0 and pending register cleared.
REQ-031 Reset SHALL take precedence over all other inputs, including in mid-request (FETCH with mem_ready=0).
REQ-032 After reset release, the FSM SHALL stay in IDLE until start=1.

Verification
REQ-033 The bench SHALL check: reset, start=1, mem_ready held 1, mem_rdata=i -> pc sequence 00,04,08,0C, instr_valid pulse each cycle, instr=previous mem_rdata.
REQ-034 The bench SHALL check: pc=FC, accept -> pc=00, no glitch on mem_req.
REQ-035 The bench SHALL check: mem_ready=0 for 3 cycles, br_valid with target 40 then target 80 during the stall, then accept -> pc held, then next pc=80, pending cleared so the following accept gives 84.
REQ-036 The bench SHALL check: br_valid=1 with target 20 on the same cycle as accept at pc=10 -> instr from 10 valid, next pc=20.
REQ-037 The bench SHALL check: halt=1 while stalled at pc=08 -> mem_req stays 1 until mem_ready, then state HALTED and pc=0C; start -> FETCH at 0C.
REQ-038 The bench SHALL check: rst_n=0 during a stalled FETCH at pc=30 with pending target 50 -> next cycle IDLE, pc=00, mem_req=0; after start, the first accept gives pc=04 (pending target discarded).

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/HALTED control with a held-request memory
// handshake, branch redirects and a latest-wins pending branch target.
module fetch_sequencer #(
  parameter int unsigned STEP     = 4,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       halt,
  input  logic       br_valid,
  input  logic [7:0] br_target,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic       mem_req,
  output logic [7:0] pc,
  output logic [7:0] instr,
  output logic       instr_valid,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [7:0] STEP_B = 8'(STEP);

  state_t     state_reg;
  logic [7:0] pc_reg;
  logic [7:0] instr_reg;
  logic       instr_valid_reg;
  logic       mem_req_reg;
  logic [7:0] pend_target_reg;
  logic       pend_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 8'h00;
      instr_valid_reg <= 1'b0;
      mem_req_reg     <= 1'b0;
      pend_target_reg <= 8'h00;
      pend_valid_reg  <= 1'b0;
    end else begin
      instr_valid_reg <= 1'b0;
      case (state_reg)
        FETCH: begin
          if (mem_ready) begin
            instr_reg       <= mem_rdata;
            instr_valid_reg <= 1'b1;
            // A same-cycle branch beats an older pending one.
            if (br_valid)            pc_reg <= br_target;
            else if (pend_valid_reg) pc_reg <= pend_target_reg;
            else                     pc_reg <= pc_reg + STEP_B;
            pend_valid_reg  <= 1'b0;
            if (halt) begin
              state_reg   <= HALTED;
              mem_req_reg <= 1'b0;
            end
          end else if (br_valid) begin
            // Request is outstanding: pc must stay put, so park the redirect.
            pend_target_reg <= br_target;
            pend_valid_reg  <= 1'b1;
          end
        end
        IDLE, HALTED: begin
          if (br_valid) begin
            pc_reg         <= br_target;
            pend_valid_reg <= 1'b0;
          end
          if (halt) begin
            state_reg   <= HALTED;
            mem_req_reg <= 1'b0;
          end else if (start) begin
            state_reg   <= FETCH;
            mem_req_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign state_o     = state_reg;

endmodule
